// File: rtl/game_pkg.sv
// Shared definitions for the stacking game: FSM state encoding and
// screen/block geometry so the scheduler and stack agree on sizes.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPAWN  = 3'd1,
        FALL   = 3'd2,
        PAUSED = 3'd3,
        WIN    = 3'd4,
        LOSE   = 3'd5
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BLOCK_H  = 20;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every clock.
// Ports: clk, rst (async active-low), o_value = current register value.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/drop_scheduler.sv
// Game sequencer: spawns one falling block at a time, advances it on a
// divided tick, retires it on collision or floor miss, tracks pause/win/lose.
// Inputs: clk, rst (async active-low), start, pause_btn, collision, height.
// Outputs: fall_x/fall_y/fall_color/fall_active, pause, stack_clr, misses,
//          state, game_over, win.  All driven from registers.
module drop_scheduler
    import game_pkg::*;
#(
    parameter int TICK_W     = 18,
    parameter int FALL_STEP  = 2,
    parameter int SPAWN_Y    = 0,
    parameter int PARK_Y     = 0,
    parameter int FLOOR_Y    = 470,
    parameter int X_MIN      = 20,
    parameter int X_MAX      = 470,
    parameter int MAX_MISS   = 3,
    parameter int WIN_HEIGHT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       collision,
    input  logic [9:0] height,
    output logic [9:0] fall_x,
    output logic [9:0] fall_y,
    output logic [1:0] fall_color,
    output logic       fall_active,
    output logic       pause,
    output logic       stack_clr,
    output logic [1:0] misses,
    output logic [2:0] state,
    output logic       game_over,
    output logic       win
);

    localparam logic [9:0] L_STEP  = 10'(FALL_STEP);
    localparam logic [9:0] L_SPAWN = 10'(SPAWN_Y);
    localparam logic [9:0] L_PARK  = 10'(PARK_Y);
    localparam logic [9:0] L_FLOOR = 10'(FLOOR_Y);
    localparam logic [9:0] L_XMIN  = 10'(X_MIN);
    localparam logic [9:0] L_XMAX  = 10'(X_MAX);
    localparam logic [9:0] L_WIN_H = 10'(WIN_HEIGHT);
    localparam logic [1:0] L_MAXM  = 2'(MAX_MISS);

    state_t            r_state;
    logic [TICK_W-1:0] r_div;
    logic              r_start_q;
    logic              r_pause_q;
    logic              r_coll_q;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [1:0]        r_color;
    logic              r_active;
    logic              r_pause;
    logic              r_clr;
    logic [1:0]        r_miss;

    logic [15:0]       w_lfsr;
    logic [4:0]        w_lfsr_unused;
    logic              w_tick;
    logic              w_start_p;
    logic              w_pause_p;
    logic              w_coll_p;
    logic [9:0]        w_y_next;
    logic              w_floor;
    logic [9:0]        w_x_raw;
    logic [9:0]        w_x_spawn;
    logic [1:0]        w_color;
    logic [1:0]        w_miss_next;

    lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_value (w_lfsr)
    );

    assign w_lfsr_unused = w_lfsr[15:11];

    assign w_tick    = (r_div == '0);
    assign w_start_p = start & ~r_start_q;
    assign w_pause_p = pause_btn & ~r_pause_q;
    // A collision held for several cycles must retire only one block.
    assign w_coll_p  = collision & ~r_coll_q;

    assign w_y_next  = r_y + L_STEP;
    assign w_floor   = (w_y_next >= L_FLOOR);

    // Spawn x folds values past the right edge back by 256.
    assign w_x_raw   = L_XMIN + {1'b0, w_lfsr[8:0]};
    assign w_x_spawn = (w_x_raw > L_XMAX) ? (w_x_raw - 10'd256) : w_x_raw;
    assign w_color   = (w_lfsr[10:9] == 2'b00) ? 2'b01 : w_lfsr[10:9];

    assign w_miss_next = (r_miss == L_MAXM) ? r_miss : (r_miss + 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_start_q <= 1'b0;
            r_pause_q <= 1'b0;
            r_coll_q  <= 1'b0;
            r_x       <= '0;
            r_y       <= L_PARK;
            r_color   <= 2'b00;
            r_active  <= 1'b0;
            r_pause   <= 1'b1;
            r_clr     <= 1'b0;
            r_miss    <= 2'd0;
        end else begin
            r_div     <= r_div + 1'b1;
            r_start_q <= start;
            r_pause_q <= pause_btn;
            r_coll_q  <= collision;
            r_clr     <= 1'b0;
            unique case (r_state)
                IDLE, WIN, LOSE: begin
                    if (w_start_p) begin
                        r_clr   <= 1'b1;
                        r_miss  <= 2'd0;
                        r_state <= SPAWN;
                    end
                end
                SPAWN: begin
                    if (height >= L_WIN_H) begin
                        r_active <= 1'b0;
                        r_state  <= WIN;
                    end else begin
                        r_x      <= w_x_spawn;
                        r_color  <= w_color;
                        r_y      <= L_SPAWN;
                        r_active <= 1'b1;
                        r_pause  <= 1'b0;
                        r_state  <= FALL;
                    end
                end
                FALL: begin
                    if (w_coll_p) begin
                        r_active <= 1'b0;
                        r_y      <= L_PARK;
                        r_pause  <= 1'b1;
                        r_state  <= SPAWN;
                    end else if (w_tick && w_floor) begin
                        r_active <= 1'b0;
                        r_y      <= L_PARK;
                        r_miss   <= w_miss_next;
                        r_pause  <= 1'b1;
                        r_state  <= (w_miss_next == L_MAXM) ? LOSE : SPAWN;
                    end else if (w_pause_p) begin
                        r_pause <= 1'b1;
                        r_state <= PAUSED;
                    end else if (w_tick) begin
                        r_y <= w_y_next;
                    end
                end
                PAUSED: begin
                    if (w_pause_p) begin
                        r_pause <= 1'b0;
                        r_state <= FALL;
                    end
                end
                default: begin
                    r_pause <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fall_x      = r_x;
    assign fall_y      = r_y;
    assign fall_color  = r_color;
    assign fall_active = r_active;
    assign pause       = r_pause;
    assign stack_clr   = r_clr;
    assign misses      = r_miss;
    assign state       = r_state;
    assign game_over   = (r_state == LOSE);
    assign win         = (r_state == WIN);

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed + randomized bench for drop_scheduler (TICK_W=4).
// Expected values come from cycle counting and the LFSR recurrence.
module tb_drop_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause_btn = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] height = 10'd0;
    logic [9:0] fall_x;
    logic [9:0] fall_y;
    logic [1:0] fall_color;
    logic       fall_active;
    logic       pause;
    logic       stack_clr;
    logic [1:0] misses;
    logic [2:0] state;
    logic       game_over;
    logic       win;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [15:0] m_used = 16'hACE1;

    always #5 clk = ~clk;

    drop_scheduler #(
        .TICK_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause_btn   (pause_btn),
        .collision   (collision),
        .height      (height),
        .fall_x      (fall_x),
        .fall_y      (fall_y),
        .fall_color  (fall_color),
        .fall_active (fall_active),
        .pause       (pause),
        .stack_clr   (stack_clr),
        .misses      (misses),
        .state       (state),
        .game_over   (game_over),
        .win         (win)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Divider starts at 0 after reset: edges 1, 17, 33, ... are ticks.
    function automatic bit is_tick(input int k);
        return ((k - 1) % 16) == 0;
    endfunction

    function automatic int count_ticks(input int k0, input int k1);
        int n = 0;
        for (int k = k0 + 1; k <= k1; k++) if (is_tick(k)) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        ncyc++;
        m_used = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic chk_spawn(input string tag);
        int x;
        int c;
        x = 20 + int'(m_used[8:0]);
        if (x > 470) x = x - 256;
        c = int'(m_used[10:9]);
        if (c == 0) c = 1;
        chk({tag, "_state"}, state, 2);
        chk({tag, "_active"}, fall_active, 1);
        chk({tag, "_y"}, fall_y, 0);
        chk({tag, "_x"}, fall_x, x);
        chk({tag, "_color"}, fall_color, c);
        chk({tag, "_xrange"}, int'(fall_x >= 20 && fall_x <= 470), 1);
        chk({tag, "_cnz"}, int'(fall_color != 2'b00), 1);
    endtask

    task automatic fall_to_floor(output int lasty);
        int g = 0;
        lasty = -1;
        while (state == 3'd2 && g < 6000) begin
            lasty = fall_y;
            clk1();
            g++;
        end
    endtask

    initial begin
        int ks;
        int g;
        int bad;
        int lasty;

        #23;
        chk("rst_state", state, 0);
        chk("rst_x", fall_x, 0);
        chk("rst_y", fall_y, 0);
        chk("rst_color", fall_color, 0);
        chk("rst_active", fall_active, 0);
        chk("rst_pause", pause, 1);
        chk("rst_clr", stack_clr, 0);
        chk("rst_miss", misses, 0);
        chk("rst_over", game_over, 0);
        chk("rst_win", win, 0);

        @(negedge clk);
        rst = 1'b1;
        ncyc = 0;
        m_lfsr = 16'hACE1;

        repeat (3) clk1();
        chk("idle_hold", state, 0);

        start = 1'b1;
        clk1();
        chk("st_spawn", state, 1);
        chk("st_clr", stack_clr, 1);
        chk("st_miss", misses, 0);
        clk1();
        chk("st_clr_off", stack_clr, 0);
        chk("st_pause", pause, 0);
        chk_spawn("sp0");
        ks = ncyc;
        start = 1'b0;
        repeat (16) clk1();
        chk("y_16clk", fall_y, 2 * count_ticks(ks, ncyc));
        chk("y_16clk_two", fall_y, 2);

        collision = 1'b1;
        clk1();
        chk("col_state", state, 1);
        chk("col_y", fall_y, 0);
        chk("col_active", fall_active, 0);
        chk("col_miss", misses, 0);
        clk1();
        chk_spawn("sp_col");
        ks = ncyc;
        clk1();
        chk("col_noretrig", state, 2);
        collision = 1'b0;
        bad = 0;
        repeat (10) begin
            clk1();
            if (state == 3'd1) bad++;
        end
        chk("col_one_spawn", bad, 0);
        chk("col_y_after", fall_y, 2 * count_ticks(ks, ncyc));
        chk("col_miss2", misses, 0);

        g = 0;
        while (fall_y != 10'd100 && g < 2000) begin
            clk1();
            g++;
        end
        chk("reach_100", fall_y, 100);
        pause_btn = 1'b1;
        clk1();
        chk("pz_state", state, 3);
        chk("pz_pause", pause, 1);
        chk("pz_y", fall_y, 100);
        bad = 0;
        repeat (1000) begin
            clk1();
            if (fall_y != 10'd100 || state != 3'd3) bad++;
        end
        chk("pz_hold", bad, 0);
        pause_btn = 1'b0;
        clk1();
        chk("pz_release", state, 3);
        pause_btn = 1'b1;
        clk1();
        chk("pz_resume", state, 2);
        chk("pz_resume_p", pause, 0);
        chk("pz_resume_y", fall_y, 100);
        pause_btn = 1'b0;

        fall_to_floor(lasty);
        chk("m1_state", state, 1);
        chk("m1_miss", misses, 1);
        chk("m1_y", fall_y, 0);
        chk("m1_active", fall_active, 0);
        chk("m1_lasty", lasty, 468);
        chk("m1_ontick", int'(is_tick(ncyc)), 1);
        clk1();
        chk_spawn("sp_m1");

        g = 0;
        while ((fall_y != 10'd468 || !is_tick(ncyc + 1)) && g < 6000) begin
            clk1();
            g++;
        end
        chk("cf_setup", fall_y, 468);
        collision = 1'b1;
        pause_btn = 1'b1;
        clk1();
        collision = 1'b0;
        chk("cf_state", state, 1);
        chk("cf_miss", misses, 1);
        clk1();
        chk_spawn("sp_cf");
        pause_btn = 1'b0;
        clk1();
        chk("cf_nopause", state, 2);

        fall_to_floor(lasty);
        chk("m2_state", state, 1);
        chk("m2_miss", misses, 2);
        clk1();
        chk_spawn("sp_m2");
        fall_to_floor(lasty);
        chk("m3_state", state, 5);
        chk("m3_miss", misses, 3);
        chk("m3_over", game_over, 1);
        chk("m3_pause", pause, 1);
        chk("m3_active", fall_active, 0);
        repeat (5) clk1();
        chk("lose_hold", state, 5);

        start = 1'b1;
        clk1();
        chk("rs_state", state, 1);
        chk("rs_clr", stack_clr, 1);
        chk("rs_miss", misses, 0);
        chk("rs_over", game_over, 0);
        clk1();
        chk_spawn("sp_rs");
        start = 1'b0;

        height = 10'd16;
        collision = 1'b1;
        clk1();
        collision = 1'b0;
        clk1();
        chk("win_state", state, 4);
        chk("win_flag", win, 1);
        chk("win_active", fall_active, 0);
        chk("win_pause", pause, 1);
        clk1();
        chk("win_hold", state, 4);
        start = 1'b1;
        clk1();
        chk("wr_clr", stack_clr, 1);
        chk("wr_miss", misses, 0);
        chk("wr_state", state, 1);
        height = 10'd0;
        clk1();
        chk_spawn("sp_wr");
        start = 1'b0;

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 20)) clk1();
            height = 10'($urandom_range(0, 15));
            collision = 1'b1;
            clk1();
            collision = 1'b0;
            chk("rnd_spawn", state, 1);
            clk1();
            chk_spawn("rnd");
        end

        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_clr", stack_clr, 0);
        chk("arst_active", fall_active, 0);
        chk("arst_pause", pause, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
